// File: rtl/sha_result_merge_if.sv
// Stream bundle between the SHA engine outputs, the merge block and the return path.
// The "slave" modport is the merge block; "master" is the surrounding logic.
interface sha_result_merge_if #(
   parameter int unsigned SWITCH_DATA_WIDTH = 512,
   parameter int unsigned SWITCH_KEEP_WIDTH = SWITCH_DATA_WIDTH / 8,
   parameter int unsigned DESC_WIDTH        = 128
);
   logic [DESC_WIDTH-1:0]        s_desc_tdata;
   logic                         s_desc_tvalid;
   logic                         s_desc_tready;

   logic [511:0]                 s_sha_tdata;
   logic                         s_sha_tvalid;
   logic                         s_sha_tready;

   logic [SWITCH_DATA_WIDTH-1:0] s_data_tdata;
   logic [SWITCH_KEEP_WIDTH-1:0] s_data_tkeep;
   logic                         s_data_tvalid;
   logic                         s_data_tready;
   logic                         s_data_tlast;

   logic [SWITCH_DATA_WIDTH-1:0] m_axis_tdata;
   logic [SWITCH_KEEP_WIDTH-1:0] m_axis_tkeep;
   logic                         m_axis_tvalid;
   logic                         m_axis_tready;
   logic                         m_axis_tlast;

   modport slave (
      input  s_desc_tdata, s_desc_tvalid,
      output s_desc_tready,
      input  s_sha_tdata, s_sha_tvalid,
      output s_sha_tready,
      input  s_data_tdata, s_data_tkeep, s_data_tvalid, s_data_tlast,
      output s_data_tready,
      output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
      input  m_axis_tready
   );

   modport master (
      output s_desc_tdata, s_desc_tvalid,
      input  s_desc_tready,
      output s_sha_tdata, s_sha_tvalid,
      input  s_sha_tready,
      output s_data_tdata, s_data_tkeep, s_data_tvalid, s_data_tlast,
      input  s_data_tready,
      input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
      output m_axis_tready
   );
endinterface

// File: rtl/sha_result_merge.sv
// Rebuilds one output packet per SHA job: descriptor beat, optional digest beat, payload beats.
// A single output register decouples the three input streams from the return path.
`ifndef PANIC_DESC_WIDTH
`define PANIC_DESC_WIDTH 128
`endif

module sha_result_merge #(
   parameter int unsigned SWITCH_DATA_WIDTH = 512,
   parameter int unsigned SWITCH_KEEP_WIDTH = SWITCH_DATA_WIDTH / 8,
   parameter int unsigned DESC_WIDTH        = `PANIC_DESC_WIDTH,
   parameter bit          APPEND_DIGEST     = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   sha_result_merge_if.slave bus,
   output logic [31:0]       pkt_count,
   output logic              busy
);

   typedef enum logic [1:0] {StIdle, StDesc, StDigest, StData} state_e;

   state_e                       state_q, state_d;
   logic                         adv;
   logic                         load;
   logic [SWITCH_DATA_WIDTH-1:0] load_data;
   logic [SWITCH_KEEP_WIDTH-1:0] load_keep;
   logic                         load_last;
   logic                         pkt_done;

   logic                         m_valid_q;
   logic [SWITCH_DATA_WIDTH-1:0] m_data_q;
   logic [SWITCH_KEEP_WIDTH-1:0] m_keep_q;
   logic                         m_last_q;
   logic [31:0]                  pkt_count_q;

   assign adv = !m_valid_q || bus.m_axis_tready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Leave IDLE only once both header sources are present, so the digest is never in flight.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (bus.s_desc_tvalid && bus.s_sha_tvalid) state_d = StDesc;
         StDesc:   if (bus.s_desc_tvalid && adv) state_d = StDigest;
         StDigest: if (bus.s_sha_tvalid && adv) state_d = StData;
         StData:   if (bus.s_data_tvalid && adv && bus.s_data_tlast) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.s_desc_tready = 1'b0;
      bus.s_sha_tready  = 1'b0;
      bus.s_data_tready = 1'b0;
      load              = 1'b0;
      load_data         = '0;
      load_keep         = '1;
      load_last         = 1'b0;
      pkt_done          = 1'b0;
      unique case (state_q)
         StDesc: begin
            bus.s_desc_tready           = adv;
            load                        = bus.s_desc_tvalid && adv;
            load_data[DESC_WIDTH-1:0]   = bus.s_desc_tdata;
         end
         StDigest: begin
            bus.s_sha_tready = adv;
            // Without APPEND_DIGEST the digest is popped but never reaches the output.
            load             = APPEND_DIGEST && bus.s_sha_tvalid && adv;
            load_data[511:0] = bus.s_sha_tdata;
         end
         StData: begin
            bus.s_data_tready = adv;
            load              = bus.s_data_tvalid && adv;
            load_data         = bus.s_data_tdata;
            load_keep         = bus.s_data_tkeep;
            load_last         = bus.s_data_tlast;
            pkt_done          = bus.s_data_tvalid && adv && bus.s_data_tlast;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_keep_q  <= '0;
         m_last_q  <= 1'b0;
      end else if (adv) begin
         m_valid_q <= load;
         if (load) begin
            m_data_q <= load_data;
            m_keep_q <= load_keep;
            m_last_q <= load_last;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_count_q <= '0;
      end else if (pkt_done) begin
         pkt_count_q <= pkt_count_q + 32'd1;
      end
   end

   assign bus.m_axis_tvalid = m_valid_q;
   assign bus.m_axis_tdata  = m_data_q;
   assign bus.m_axis_tkeep  = m_keep_q;
   assign bus.m_axis_tlast  = m_last_q;
   assign pkt_count         = pkt_count_q;
   assign busy              = (state_q != StIdle);

endmodule
